// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults and types for the MIPS memory responder.
// Holds the default memory map (base address, depth, loader start address),
// the 32-bit word type and the responder's FSM state type.
package mem_pkg;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'h8000_0000;
    localparam int          DEF_DEPTH_WORDS = 2**19;
    localparam logic [31:0] DEF_LOAD_BASE   = 32'h8002_0000;
    typedef logic [31:0] word_t;
    typedef enum logic {S_LOAD, S_RUN} state_t;
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: word storage with one write port and two registered write-first read ports.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr_a/i_raddr_b read addresses;
// o_rdata_a/o_rdata_b read data, valid one edge after the address. No reset: contents persist.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output word_t         o_rdata_a,
    output word_t         o_rdata_b
);
    word_t r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata_a <= (i_we && i_waddr == i_raddr_a) ? i_wdata : r_mem[i_raddr_a];
        o_rdata_b <= (i_we && i_waddr == i_raddr_b) ? i_wdata : r_mem[i_raddr_b];
    end
endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: loader-then-run memory model serving a MIPS core's instruction and data ports.
// Ports: clk, reset (async active-low); instr_addr -> instr_in; data_addr/data_out/data_rd_wr -> data_in;
// load_valid/load_data/load_done -> load_ready; run; sticky err_misalign/err_range; saturating err_count.
module mips_mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter logic [31:0] LOAD_BASE   = DEF_LOAD_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_in,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_rd_wr,
    output logic [31:0] data_in,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_done,
    output logic        load_ready,
    output logic        run,
    output logic        err_misalign,
    output logic        err_range,
    output logic [7:0]  err_count
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    state_t      r_state;
    word_t       r_lptr;
    logic        r_i_ok, r_d_ok;
    word_t       w_i_off, w_d_off, w_l_off, w_rd_i, w_rd_d, w_wdata;
    logic        w_i_rng, w_d_rng, w_l_rng, w_i_mis, w_d_mis;
    logic        w_i_ok, w_d_ok, w_mis_evt, w_rng_evt, w_we;
    logic [AW-1:0] w_waddr;

    assign w_i_off = instr_addr - BASE_ADDR;
    assign w_d_off = data_addr - BASE_ADDR;
    assign w_l_off = r_lptr - BASE_ADDR;
    assign w_i_rng = (instr_addr >= BASE_ADDR) && ({1'b0, w_i_off} < LIMIT);
    assign w_d_rng = (data_addr >= BASE_ADDR) && ({1'b0, w_d_off} < LIMIT);
    assign w_l_rng = (r_lptr >= BASE_ADDR) && ({1'b0, w_l_off} < LIMIT);
    assign w_i_mis = instr_addr[1:0] != 2'b00;
    assign w_d_mis = data_addr[1:0] != 2'b00;
    assign w_i_ok  = run && w_i_rng && !w_i_mis;
    assign w_d_ok  = run && w_d_rng && !w_d_mis;
    // Core-port errors only count while running; during load only a dropped loader word is an error.
    assign w_mis_evt = run && (w_i_mis || w_d_mis);
    assign w_rng_evt = run ? (!w_i_rng || !w_d_rng) : (load_valid && !w_l_rng);
    assign w_we      = run ? (!data_rd_wr && w_d_ok) : (load_valid && w_l_rng);
    assign w_waddr   = run ? w_d_off[AW+1:2] : w_l_off[AW+1:2];
    assign w_wdata   = run ? data_out : load_data;

    mem_word_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_mem (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_i_off[AW+1:2]),
        .i_raddr_b (w_d_off[AW+1:2]),
        .o_rdata_a (w_rd_i),
        .o_rdata_b (w_rd_d)
    );

    // The array has no reset, so the registered validity bits gate the read data to zero.
    assign instr_in = r_i_ok ? w_rd_i : '0;
    assign data_in  = r_d_ok ? w_rd_d : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_LOAD;
            r_lptr       <= LOAD_BASE;
            r_i_ok       <= 1'b0;
            r_d_ok       <= 1'b0;
            load_ready   <= 1'b1;
            run          <= 1'b0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
            err_count    <= '0;
        end else begin
            r_i_ok <= w_i_ok;
            r_d_ok <= w_d_ok;
            if (w_mis_evt) err_misalign <= 1'b1;
            if (w_rng_evt) err_range <= 1'b1;
            if ((w_mis_evt || w_rng_evt) && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (r_state == S_LOAD) begin
                // A dropped word leaves the pointer parked past the end instead of wrapping.
                if (load_valid && w_l_rng) r_lptr <= r_lptr + 32'd4;
                if (load_done) begin
                    r_state    <= S_RUN;
                    run        <= 1'b1;
                    load_ready <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: directed self-checking bench for mips_mem_responder.
module tb_mips_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_addr = 32'h8000_0000, data_addr = 32'h8000_0000, data_out = '0, load_data = '0;
    logic        data_rd_wr = 1'b1, load_valid = 1'b0, load_done = 1'b0;
    logic [31:0] instr_in, data_in;
    logic        load_ready, run, err_misalign, err_range;
    logic [7:0]  err_count;
    logic [31:0] s_instr_in, s_data_in;
    logic        s_load_ready, s_run, s_err_misalign, s_err_range;
    logic [7:0]  s_err_count;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    mips_mem_responder u_dut (
        .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_in(instr_in),
        .data_addr(data_addr), .data_out(data_out), .data_rd_wr(data_rd_wr), .data_in(data_in),
        .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
        .load_ready(load_ready), .run(run), .err_misalign(err_misalign),
        .err_range(err_range), .err_count(err_count)
    );

    // Four-word instance: loader starts at word 2, so the third loaded word overflows.
    mips_mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4), .LOAD_BASE(32'h8000_0008)) u_small (
        .clk(clk), .reset(reset), .instr_addr(32'h8000_000C), .instr_in(s_instr_in),
        .data_addr(32'h8000_0008), .data_out(32'h0), .data_rd_wr(1'b1), .data_in(s_data_in),
        .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
        .load_ready(s_load_ready), .run(s_run), .err_misalign(s_err_misalign),
        .err_range(s_err_range), .err_count(s_err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_in", instr_in, 32'h0);
        check("rst_data_in", data_in, 32'h0);
        check("rst_load_ready", {31'b0, load_ready}, 32'h1);
        check("rst_run", {31'b0, run}, 32'h0);
        check("rst_errs", {err_misalign, err_range, err_count}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        // Scenario 1: three loader words, last one together with load_done.
        tick();
        load_valid = 1'b1; load_data = 32'h2402_0005; instr_addr = 32'h8002_0000;
        tick();
        load_data = 32'h0000_0000;
        data_rd_wr = 1'b0; data_addr = 32'h8002_0000; data_out = 32'hBAD0_BAD0;
        instr_addr = 32'h8000_0001;
        tick();
        check("load_read_zero", instr_in, 32'h0);
        check("load_no_err", {24'b0, err_count}, 32'h0);
        load_data = 32'h03E0_0008; load_done = 1'b1; data_rd_wr = 1'b1;
        tick();
        load_valid = 1'b0; load_done = 1'b0; load_data = '0;
        instr_addr = 32'h8002_0008; data_addr = 32'h8002_0000;
        check("run_after_done", {31'b0, run}, 32'h1);
        check("load_ready_low", {31'b0, load_ready}, 32'h0);
        check("small_ovf_range", {31'b0, s_err_range}, 32'h1);
        check("small_ovf_count", {24'b0, s_err_count}, 32'h1);
        tick();
        check("s1_instr", instr_in, 32'h03E0_0008);
        check("s1_load_word0_kept", data_in, 32'h2402_0005);
        check("s1_errs", {err_misalign, err_range, err_count}, 32'h0);
        check("small_data_word2", s_data_in, 32'h2402_0005);
        check("small_count_held", {24'b0, s_err_count}, 32'h1);
        // Scenario 2: write-first on both ports.
        data_rd_wr = 1'b0; data_addr = 32'h8011_FFFC; data_out = 32'hCAFE_F00D; instr_addr = 32'h8011_FFFC;
        tick();
        check("s2_instr_wf", instr_in, 32'hCAFE_F00D);
        check("s2_data_wf", data_in, 32'hCAFE_F00D);
        // Last word in range.
        data_addr = 32'h801F_FFFC; data_out = 32'h0BAD_CAFE;
        tick();
        data_rd_wr = 1'b1; instr_addr = 32'h801F_FFFC; data_addr = 32'h8011_FFFC;
        tick();
        check("last_word_instr", instr_in, 32'h0BAD_CAFE);
        check("s2_readback", data_in, 32'hCAFE_F00D);
        check("last_word_no_err", {24'b0, err_count}, 32'h0);
        // Scenario 3: misaligned write is suppressed.
        data_rd_wr = 1'b0; data_addr = 32'h8010_0000; data_out = 32'h5A5A_5A5A; instr_addr = 32'h8002_0008;
        tick();
        data_addr = 32'h8010_0002; data_out = 32'hFFFF_FFFF;
        tick();
        check("s3_data_zero", data_in, 32'h0);
        check("s3_misalign", {31'b0, err_misalign}, 32'h1);
        check("s3_count", {24'b0, err_count}, 32'h1);
        check("s3_range_clear", {31'b0, err_range}, 32'h0);
        data_rd_wr = 1'b1; data_addr = 32'h8010_0000;
        tick();
        check("s3_word_kept", data_in, 32'h5A5A_5A5A);
        // Scenario 4: out-of-range reads after a reset with load_done only.
        reset = 1'b0;
        #1;
        check("async_rst_run", {31'b0, run}, 32'h0);
        check("async_rst_data", data_in, 32'h0);
        check("async_rst_count", {24'b0, err_count}, 32'h0);
        @(negedge clk);
        reset = 1'b1; load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("s4_run", {31'b0, run}, 32'h1);
        data_addr = 32'h7FFF_FFFC;
        tick();
        check("s4_low_zero", data_in, 32'h0);
        check("s4_range", {31'b0, err_range}, 32'h1);
        check("s4_count1", {24'b0, err_count}, 32'h1);
        data_addr = 32'h8020_0000;
        tick();
        check("s4_high_zero", data_in, 32'h0);
        check("s4_count2", {24'b0, err_count}, 32'h2);
        check("s4_no_misalign", {31'b0, err_misalign}, 32'h0);
        data_addr = 32'h8010_0000; instr_addr = 32'h8002_000A;
        tick();
        check("instr_mis_zero", instr_in, 32'h0);
        check("instr_mis_flag", {31'b0, err_misalign}, 32'h1);
        check("instr_mis_count", {24'b0, err_count}, 32'h3);
        // Scenario 5: saturation.
        instr_addr = 32'h8002_0008; data_addr = 32'h8010_0001;
        repeat (300) tick();
        check("s5_saturate", {24'b0, err_count}, 32'hFF);
        tick();
        check("s5_hold", {24'b0, err_count}, 32'hFF);
        // Scenario 6: memory survives a mid-run reset.
        data_rd_wr = 1'b0; data_addr = 32'h8003_0000; data_out = 32'h1234_5678;
        tick();
        data_rd_wr = 1'b1;
        reset = 1'b0;
        #1;
        check("s6_rst_ready", {31'b0, load_ready}, 32'h1);
        check("s6_rst_instr", instr_in, 32'h0);
        @(negedge clk);
        reset = 1'b1; load_done = 1'b1;
        tick();
        load_done = 1'b0;
        tick();
        check("s6_word_kept", data_in, 32'h1234_5678);
        check("s6_load_kept", instr_in, 32'h03E0_0008);
        check("s6_flags_clear", {err_misalign, err_range, err_count}, 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h80000000, byte address of word 0.
REQ-002 Parameter: DEPTH_WORDS, 2**19, memory size in 32-bit words (covers 0x80000000-0x801FFFFF).
REQ-003 Parameter: LOAD_BASE, 32'h80020000, first byte address written by the loader.
REQ-004 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: instr_addr  in  32  instruction fetch byte address.
REQ-007 Port: instr_in  out  32  fetched instruction word.
REQ-008 Port: data_addr  in  32  data byte address.
REQ-009 Port: data_out  in  32  store data from the core.
REQ-010 Port: data_rd_wr  in  1  1=read, 0=write.
REQ-011 Port: data_in  out  32  load data returned to the core.
REQ-012 Port: load_valid  in  1  loader word present.
REQ-013 Port: load_data  in  32  loader word.
REQ-014 Port: load_done  in  1  one-cycle pulse ending the load phase.
REQ-015 Port: load_ready  out  1  loader may present words.
REQ-016 Port: run  out  1  core ports are serviced.
REQ-017 Port: err_misalign  out  1  sticky misaligned-access flag.
REQ-018 Port: err_range  out  1  sticky out-of-range-access flag.
REQ-019 Port: err_count  out  8  saturating error-event counter.

Function
REQ-020 FSM states: S_LOAD and S_RUN; S_LOAD is entered on reset; S_LOAD->S_RUN on load_done=1; S_RUN is left only by reset.
REQ-021 In S_LOAD: load_ready=1, run=0; a word is accepted on each edge with load_valid=1 and written at load pointer, which then advances by 4.
REQ-022 Load pointer starts at LOAD_BASE; a word whose pointer is beyond the last word is dropped, sets err_range and increments err_count, and the pointer does not wrap.
REQ-023 load_valid and load_done in the same cycle: the word is accepted first, then the FSM moves to S_RUN.
REQ-024 In S_RUN: load_ready=0, run=1; load_valid and load_done are ignored.
REQ-025 Word index = (addr - BASE_ADDR) >> 2; an address is in range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
REQ-026 Reads are registered, latency 1: instr_in and data_in reflect the address sampled on the previous edge.
REQ-027 data_rd_wr=0 in S_RUN writes data_out to the addressed word on the edge; repeated writes over consecutive cycles are permitted and idempotent.
REQ-028 Write-first: a read on either port hitting the word being written in the same cycle returns the new data.
REQ-029 A misaligned data access (data_addr[1:0]!=0) suppresses any write, returns 0 on data_in and sets err_misalign.
REQ-030 A misaligned instr_addr returns 0 on instr_in and sets err_misalign.
REQ-031 An out-of-range access on either port returns 0 and suppresses any write, and sets err_range.
REQ-032 err_count increments by 1 per cycle containing at least one error event and saturates at 255.
REQ-033 In S_LOAD, core reads return 0, core writes are ignored, and they raise no errors.

Reset
REQ-034 reset=0 asynchronously forces instr_in=0, data_in=0, load_ready=1, run=0, err_misalign=0, err_range=0, err_count=0, load pointer=LOAD_BASE and FSM=S_LOAD.
REQ-035 Memory contents are not cleared by reset; a reset mid-load or mid-run preserves all written words.
REQ-036 Deassertion of reset takes effect at the next rising clk edge.

Structure
REQ-037 Package mem_pkg shall hold BASE_ADDR, LOAD_BASE, DEPTH_WORDS defaults, the state typedef (S_LOAD, S_RUN) and the 32-bit word typedef.
REQ-038 Sub-module mem_word_array shall implement the storage: one write port, two registered write-first read ports, no reset.
REQ-039 Address decode, range/alignment checks, FSM, loader pointer and error logic shall reside in mips_mem_responder.

Verification
REQ-040 Scenario 1: load 3 words 0x24020005, 0x00000000, 0x03E00008, then load_done -> run=1; instr_addr=0x80020008 yields instr_in=0x03E00008 one cycle later.
REQ-041 Scenario 2: in S_RUN write 0xCAFEF00D to 0x8011FFFC, with instr_addr=0x8011FFFC the same cycle -> next cycle instr_in=data_in=0xCAFEF00D.
REQ-042 Scenario 3: write to 0x80100002 -> err_misalign=1, err_count=1, word 0x80100000 unchanged.
REQ-043 Scenario 4: read 0x7FFFFFFC and 0x80200000 on the data port -> data_in=0 both times, err_range=1, err_count=2.
REQ-044 Scenario 5: 300 consecutive misaligned cycles -> err_count=255 and holds.
REQ-045 Scenario 6: assert reset mid-run after writing 0x12345678 to 0x80030000, then reload with load_done only -> read 0x80030000 returns 0x12345678; all flags are 0.
